qspi_flash_reader: RTL and testbench



---
 rtl/qspi_flash_pkg.sv | 37 +++
 rtl/qspi_flash_reader_if.sv | 25 ++
 rtl/qspi_flash_reader.sv | 215 +++++++++++++++++++++
 tb/tb_qspi_flash_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_flash_pkg.sv
// Shared types and constants for the QSPI flash read controller.
//   state_t        controller FSM states
//   OPC_*          flash command opcodes
//   DUMMY_FILL     byte shifted out during x1 dummy cycles
//   read_opcode()  command opcode for the selected read mode
package qspi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_CS_HOLD,
    ST_CS_IDLE
  } state_t;

  localparam logic [7:0] OPC_QUAD_READ = 8'h6B;  // Quad Output Fast Read
  localparam logic [7:0] OPC_SLOW_READ = 8'h03;  // single-lane Read Data
  localparam logic [7:0] DUMMY_FILL    = 8'h00;

  function automatic logic [7:0] read_opcode(input logic quad);
    return quad ? OPC_QUAD_READ : OPC_SLOW_READ;
  endfunction

  // Address bytes go out MSB first: idx 0 -> addr[23:16].
  function automatic logic [7:0] addr_byte(input logic [23:0] addr,
                                           input logic [1:0]  idx);
    case (idx)
      2'd0:    return addr[23:16];
      2'd1:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/qspi_flash_reader_if.sv
// Host-side read request/response bus of the QSPI flash reader.
//   rd_en/rd_addr/rd_len : start pulse with 24-bit byte address and byte count
//   rd_busy              : transaction in progress
//   rd_valid/rd_data     : one-cycle strobe with received byte (no backpressure)
//   rd_done              : one-cycle pulse at transaction end
// master = requester (host), slave = qspi_flash_reader.
interface qspi_flash_reader_if;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [15:0] rd_len;
  logic        rd_busy;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_done;

  modport master (
    output rd_en, rd_addr, rd_len,
    input  rd_busy, rd_valid, rd_data, rd_done
  );

  modport slave (
    input  rd_en, rd_addr, rd_len,
    output rd_busy, rd_valid, rd_data, rd_done
  );
endinterface

// File: rtl/qspi_flash_reader.sv
// QSPI flash read controller. Issues a Quad Output Fast Read (0x6B):
// command, 3 address bytes and DUMMY_BYTES dummy bytes on x1 through the
// byte transceiver, then one x4 burst that keeps running while auto_restart
// is high. Chip-select setup/hold/idle timing comes from one shared counter.
//   clk, rst          : clock, synchronous active-high reset
//   rd_bus (slave)    : host request/response bus
//   qspi_cs_n         : flash chip select, active low
//   shift_en          : x1 byte start pulse, tx_data valid with it
//   quad_shift_en     : x4 read start pulse
//   auto_restart      : burst-continue request to the transceiver
//   tx_data           : byte to shift out, held until its shift_done
//   shift_done        : transceiver byte-complete strobe
//   shift_rx_data     : received byte, valid with shift_done
// Timing counts clock edges: qspi_cs_n falls, CS_SETUP_CYCLES edges later
// shift_en rises; the edge that consumes the last shift_done is followed by
// CS_HOLD_CYCLES edges before qspi_cs_n rises together with rd_done.
module qspi_flash_reader
  import qspi_flash_pkg::*;
#(
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int CS_IDLE_CYCLES  = 4,
  parameter int DUMMY_BYTES     = 1
) (
  input  logic               clk,
  input  logic               rst,
  qspi_flash_reader_if.slave rd_bus,
  output logic               qspi_cs_n,
  output logic               shift_en,
  output logic               quad_shift_en,
  output logic               auto_restart,
  output logic [7:0]         tx_data,
  input  logic               shift_done,
  input  logic [7:0]         shift_rx_data
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE_CYCLES - 1);
  localparam logic [7:0]  DUMMY_LAST = 8'(DUMMY_BYTES - 1);

  state_t      state;
  logic [23:0] addr_q;
  logic [15:0] remaining;   // data bytes not yet completed
  logic [15:0] cs_cnt;      // shared CS setup/hold/idle timer
  logic [7:0]  byte_cnt;    // address byte index, then dummy byte index
  logic        rd_busy_q;
  logic        rd_valid_q;
  logic        rd_done_q;
  logic [7:0]  rd_data_q;

  assign rd_bus.rd_busy  = rd_busy_q;
  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_data  = rd_data_q;
  assign rd_bus.rd_done  = rd_done_q;

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; a blocking write would leak into later reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      qspi_cs_n     <= 1'b1;
      shift_en      <= 1'b0;
      quad_shift_en <= 1'b0;
      auto_restart  <= 1'b0;
      tx_data       <= 8'h00;
      addr_q        <= '0;
      remaining     <= '0;
      cs_cnt        <= '0;
      byte_cnt      <= '0;
      rd_busy_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_done_q     <= 1'b0;
      rd_data_q     <= 8'h00;
    end else begin
      // NOTE: strobes default low each cycle so any branch that raises one
      // produces exactly a one-cycle pulse.
      shift_en      <= 1'b0;
      quad_shift_en <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_done_q     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rd_bus.rd_en) begin
            if (rd_bus.rd_len == 16'd0) begin
              rd_done_q <= 1'b1;              // nothing to read, no CS activity
            end else begin
              addr_q    <= rd_bus.rd_addr;
              remaining <= rd_bus.rd_len;
              qspi_cs_n <= 1'b0;
              rd_busy_q <= 1'b1;
              cs_cnt    <= '0;
              if (CS_SETUP_CYCLES == 0) begin
                state    <= ST_CMD;
                shift_en <= 1'b1;
                tx_data  <= read_opcode(1'b1);
              end else begin
                state <= ST_CS_SETUP;
              end
            end
          end
        end

        ST_CS_SETUP: begin
          if (cs_cnt == SETUP_LAST) begin
            cs_cnt   <= '0;
            state    <= ST_CMD;
            shift_en <= 1'b1;
            tx_data  <= read_opcode(1'b1);
          end else begin
            cs_cnt <= cs_cnt + 16'd1;
          end
        end

        ST_CMD: begin
          if (shift_done) begin
            state    <= ST_ADDR;
            byte_cnt <= 8'd0;
            shift_en <= 1'b1;
            tx_data  <= addr_byte(addr_q, 2'd0);
          end
        end

        ST_ADDR: begin
          // byte_cnt is the index of the address byte that just completed.
          if (shift_done) begin
            if (byte_cnt != 8'd2) begin
              byte_cnt <= byte_cnt + 8'd1;
              shift_en <= 1'b1;
              tx_data  <= addr_byte(addr_q, byte_cnt[1:0] + 2'd1);
            end else if (DUMMY_BYTES == 0) begin
              state         <= ST_DATA;
              quad_shift_en <= 1'b1;
              auto_restart  <= (remaining > 16'd1);
            end else begin
              state    <= ST_DUMMY;
              byte_cnt <= 8'd0;
              shift_en <= 1'b1;
              tx_data  <= DUMMY_FILL;
            end
          end
        end

        ST_DUMMY: begin
          if (shift_done) begin
            if (byte_cnt == DUMMY_LAST) begin
              state         <= ST_DATA;
              quad_shift_en <= 1'b1;
              auto_restart  <= (remaining > 16'd1);
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              shift_en <= 1'b1;
              tx_data  <= DUMMY_FILL;
            end
          end
        end

        ST_DATA: begin
          if (shift_done) begin
            rd_data_q  <= shift_rx_data;
            rd_valid_q <= 1'b1;
            remaining  <= remaining - 16'd1;
            // Tracks remaining>1 for the value remaining takes after this edge.
            auto_restart <= (remaining > 16'd2);
            if (remaining == 16'd1) begin
              cs_cnt <= '0;
              if (CS_HOLD_CYCLES != 0) begin
                state <= ST_CS_HOLD;
              end else begin
                qspi_cs_n <= 1'b1;
                rd_done_q <= 1'b1;
                if (CS_IDLE_CYCLES == 0) begin
                  state     <= ST_IDLE;
                  rd_busy_q <= 1'b0;
                end else begin
                  state <= ST_CS_IDLE;
                end
              end
            end
          end
        end

        ST_CS_HOLD: begin
          if (cs_cnt == HOLD_LAST) begin
            cs_cnt    <= '0;
            qspi_cs_n <= 1'b1;
            rd_done_q <= 1'b1;
            if (CS_IDLE_CYCLES == 0) begin
              state     <= ST_IDLE;
              rd_busy_q <= 1'b0;
            end else begin
              state <= ST_CS_IDLE;
            end
          end else begin
            cs_cnt <= cs_cnt + 16'd1;
          end
        end

        ST_CS_IDLE: begin
          if (cs_cnt == IDLE_LAST) begin
            cs_cnt    <= '0;
            state     <= ST_IDLE;
            rd_busy_q <= 1'b0;
          end else begin
            cs_cnt <= cs_cnt + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Self-checking bench for qspi_flash_reader (default parameters).
// A behavioural transceiver answers shift_en/quad_shift_en; tx bytes and
// rd_data bytes are compared against queues filled when stimulus is issued.
module tb_qspi_flash_reader;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int XC_LAT   = 3;   // transceiver cycles per byte

  logic       clk = 1'b0;
  logic       rst;
  logic       qspi_cs_n, shift_en, quad_shift_en, auto_restart;
  logic [7:0] tx_data;
  logic       shift_done;
  logic [7:0] shift_rx_data;

  qspi_flash_reader_if bus();

  qspi_flash_reader #(
    .CS_SETUP_CYCLES(CS_SETUP),
    .CS_HOLD_CYCLES (CS_HOLD),
    .CS_IDLE_CYCLES (CS_IDLE),
    .DUMMY_BYTES    (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_bus       (bus),
    .qspi_cs_n    (qspi_cs_n),
    .shift_en     (shift_en),
    .quad_shift_en(quad_shift_en),
    .auto_restart (auto_restart),
    .tx_data      (tx_data),
    .shift_done   (shift_done),
    .shift_rx_data(shift_rx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];   // expected x1 bytes, in order
  logic [7:0] exp_rd[$];   // expected rd_data bytes, in order
  logic [7:0] rx_src[$];   // bytes the transceiver returns on x4

  // Event counters / timestamps (negedge cycle numbers)
  int cyc = 0, n_valid = 0, n_done = 0, n_shift = 0, n_quad = 0;
  int n_quad_done = 0, n_ar_cycles = 0, n_cs_low = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, first_shift_cyc = 0;
  int last_xdone_cyc = 0, done_cyc = 0, ar_fall_qd = 0;
  bit inject_stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transceiver model: acts 2 time units after each rising edge.
  initial begin
    bit   busy_x = 0, quad_x = 0;
    int   lat = 0;
    logic [7:0] cur_tx = 8'h00;
    shift_done    = 1'b0;
    shift_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      shift_done = 1'b0;
      if (rst) begin
        busy_x = 0;
        quad_x = 0;
      end else begin
        if (inject_stray) begin
          shift_done    = 1'b1;
          shift_rx_data = 8'hFF;
          inject_stray  = 1'b0;
        end else if (busy_x) begin
          if (lat > 1) begin
            lat--;
          end else begin
            shift_done = 1'b1;
            if (quad_x) begin
              shift_rx_data = (rx_src.size() != 0) ? rx_src.pop_front() : 8'hEE;
              n_quad_done++;
              if (auto_restart) lat = XC_LAT;
              else busy_x = 0;
            end else begin
              check("tx_hold", tx_data, cur_tx);
              shift_rx_data = 8'h00;
              busy_x = 0;
            end
          end
        end
        if (shift_en) begin
          n_shift++;
          check("tx_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
          cur_tx = tx_data;
          busy_x = 1; quad_x = 0; lat = XC_LAT;
        end
        if (quad_shift_en) begin
          n_quad++;
          busy_x = 1; quad_x = 1; lat = XC_LAT;
        end
      end
    end
  end

  // Output monitor: samples on the falling edge.
  initial begin
    logic prev_cs = 1'b1, prev_ar = 1'b0;
    bit   armed = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rd_valid) begin
        n_valid++;
        check("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (bus.rd_done) begin n_done++; done_cyc = cyc; end
      if (shift_done) last_xdone_cyc = cyc;
      if (auto_restart) n_ar_cycles++;
      if (prev_ar && !auto_restart) ar_fall_qd = n_quad_done;
      if (!qspi_cs_n) n_cs_low++;
      if (prev_cs && !qspi_cs_n) begin cs_fall_cyc = cyc; armed = 1; end
      if (!prev_cs && qspi_cs_n) cs_rise_cyc = cyc;
      if (armed && shift_en) begin first_shift_cyc = cyc; armed = 0; end
      prev_cs = qspi_cs_n;
      prev_ar = auto_restart;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] addr, input logic [15:0] len);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    bus.rd_len  = len;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic push_tx(input logic [23:0] addr);
    exp_tx.push_back(8'h6B);
    exp_tx.push_back(addr[23:16]);
    exp_tx.push_back(addr[15:8]);
    exp_tx.push_back(addr[7:0]);
    exp_tx.push_back(8'h00);
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step();
    check("done_seen", n_done != d0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.rd_busy; i++) step();
    check("idle_reached", bus.rd_busy, 1'b0);
  endtask

  task automatic wait_valid(input int budget);
    int v0 = n_valid;
    for (int i = 0; i < budget && n_valid == v0; i++) step();
    check("valid_seen", n_valid != v0, 1);
  endtask

  initial begin
    int v0, d0, s0, q0, qd0, a0, c0, rise;
    rst = 1'b1;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
    repeat (3) step();

    // Reset state
    check("rst_cs_n",     qspi_cs_n, 1);
    check("rst_busy",     bus.rd_busy, 0);
    check("rst_valid",    bus.rd_valid, 0);
    check("rst_done",     bus.rd_done, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_quad",     quad_shift_en, 0);
    check("rst_ar",       auto_restart, 0);
    check("rst_tx_data",  tx_data, 8'h00);
    rst = 1'b0;
    step();
    check("rel_cs_n", qspi_cs_n, 1);
    check("rel_busy", bus.rd_busy, 0);

    // 4-byte read at 0x123456
    v0 = n_valid; d0 = n_done; s0 = n_shift; q0 = n_quad; qd0 = n_quad_done;
    push_tx(24'h123456);
    foreach (rx_src[i]) ;
    rx_src.push_back(8'hA1); rx_src.push_back(8'hB2);
    rx_src.push_back(8'hC3); rx_src.push_back(8'hD4);
    exp_rd.push_back(8'hA1); exp_rd.push_back(8'hB2);
    exp_rd.push_back(8'hC3); exp_rd.push_back(8'hD4);
    issue(24'h123456, 16'd4);
    check("t1_busy_rise", bus.rd_busy, 1);
    check("t1_cs_low",    qspi_cs_n, 0);
    wait_done(200);
    wait_idle(50);
    check("t1_valid_cnt", n_valid - v0, 4);
    check("t1_done_cnt",  n_done - d0, 1);
    check("t1_shift_cnt", n_shift - s0, 5);
    check("t1_quad_cnt",  n_quad - q0, 1);
    check("t1_ar_fall",   ar_fall_qd - qd0, 3);
    check("t1_setup",     first_shift_cyc - cs_fall_cyc, CS_SETUP);
    // last shift_done is seen one negedge before the edge that consumes it
    check("t1_hold",      cs_rise_cyc - last_xdone_cyc, CS_HOLD + 1);
    check("t1_done_at_cs_rise", done_cyc, cs_rise_cyc);

    // Zero-length read
    s0 = n_shift; c0 = n_cs_low; d0 = n_done;
    issue(24'h000000, 16'd0);
    check("t2_done_next", bus.rd_done, 1);
    check("t2_cs_high",   qspi_cs_n, 1);
    check("t2_busy",      bus.rd_busy, 0);
    step();
    check("t2_done_pulse", bus.rd_done, 0);
    repeat (3) step();
    check("t2_no_shift",  n_shift - s0, 0);
    check("t2_no_cs",     n_cs_low - c0, 0);
    check("t2_done_cnt",  n_done - d0, 1);

    // Single-byte read
    v0 = n_valid; a0 = n_ar_cycles; d0 = n_done;
    push_tx(24'h000100);
    rx_src.push_back(8'h5A); exp_rd.push_back(8'h5A);
    issue(24'h000100, 16'd1);
    wait_done(200);
    wait_idle(50);
    check("t3_ar_never", n_ar_cycles - a0, 0);
    check("t3_valid_cnt", n_valid - v0, 1);
    check("t3_done_cnt",  n_done - d0, 1);
    check("t3_hold",      cs_rise_cyc - last_xdone_cyc, CS_HOLD + 1);

    // rd_en during DATA is ignored
    v0 = n_valid; d0 = n_done; s0 = n_shift; q0 = n_quad;
    push_tx(24'hFEDCBA);
    rx_src.push_back(8'h11); rx_src.push_back(8'h22); rx_src.push_back(8'h33);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    issue(24'hFEDCBA, 16'd3);
    wait_valid(200);
    issue(24'h000000, 16'd9);
    wait_done(200);
    wait_idle(50);
    check("t4_valid_cnt", n_valid - v0, 3);
    check("t4_shift_cnt", n_shift - s0, 5);
    check("t4_quad_cnt",  n_quad - q0, 1);
    check("t4_done_cnt",  n_done - d0, 1);

    // Reset in the middle of DATA; only the first byte arrives first
    v0 = n_valid; d0 = n_done; s0 = n_shift;
    push_tx(24'h00ABCD);
    for (int i = 0; i < 8; i++) rx_src.push_back(8'h81 + 8'(i));
    exp_rd.push_back(8'h81);
    issue(24'h00ABCD, 16'd8);
    wait_valid(200);
    rst = 1'b1;
    step();
    check("t5_cs_high",  qspi_cs_n, 1);
    check("t5_busy",     bus.rd_busy, 0);
    check("t5_ar",       auto_restart, 0);
    check("t5_tx_data",  tx_data, 8'h00);
    repeat (2) step();
    rst = 1'b0;
    rx_src.delete();
    step();
    inject_stray = 1'b1;
    repeat (4) step();
    check("t5_valid_cnt", n_valid - v0, 1);
    check("t5_no_done",   n_done - d0, 0);
    check("t5_shift_cnt", n_shift - s0, 5);

    // Back-to-back requests: held rd_en accepted only after CS idle time
    v0 = n_valid; d0 = n_done;
    push_tx(24'h000010);
    rx_src.push_back(8'hC1); exp_rd.push_back(8'hC1);
    issue(24'h000010, 16'd1);
    wait_done(200);
    rise = cs_rise_cyc;
    push_tx(24'h000020);
    rx_src.push_back(8'hC2); exp_rd.push_back(8'hC2);
    bus.rd_en = 1'b1; bus.rd_addr = 24'h000020; bus.rd_len = 16'd1;
    for (int i = 0; i < 20 && qspi_cs_n; i++) step();
    bus.rd_en = 1'b0;
    check("t6_cs_idle_gap", cs_fall_cyc - rise, CS_IDLE + 1);
    wait_done(200);
    wait_idle(50);
    check("t6_valid_cnt", n_valid - v0, 2);
    check("t6_done_cnt",  n_done - d0, 2);

    check("tx_queue_drained", exp_tx.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
